// File: rtl/c3_fmap_read_responder.sv
// rtl/c3_fmap_read_responder.sv - ping-pong S2->C3 feature-map buffer with 5 read lanes
// Optional out-of-range read error flag: C3_FMAP_OOR_ERR_EN
module c3_fmap_read_responder #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 32,
  parameter int LANES  = 5,
  parameter int DEPTH  = 1176
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [10:0]              wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_frame_done,
  output logic                     wr_ready,
  input  logic                     rd_en,
  input  logic [LANES*ADDR_W-1:0]  rd_addr_in_5P,
  output logic [LANES*DATA_W-1:0]  rd_data_out_5P,
  output logic                     rd_data_valid,
  output logic                     rd_frame_valid,
  input  logic                     rd_frame_done,
  output logic                     wr_drop_err,
  output logic                     oor_err
);

  localparam logic [10:0]       DEPTH_W = 11'(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  logic [DATA_W-1:0]       mem_q [2][DEPTH];
  logic [1:0]              full_q, full_d;
  logic                    wr_page_q, wr_page_d;
  logic                    rd_page_q, rd_page_d;
  logic [LANES*DATA_W-1:0] rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    drop_q, drop_d;
  logic                    rd_go;
  logic [LANES-1:0]        lane_oor;

  assign wr_ready       = !full_q[wr_page_q];
  assign rd_frame_valid = full_q[rd_page_q];
  assign rd_go          = rd_en && rd_frame_valid;

  // Writer only ever owns a non-full page, so it never collides with the read page.
  always_ff @(posedge clk) begin
    if (wr_en && wr_ready && (wr_addr < DEPTH_W)) begin
      mem_q[wr_page_q][wr_addr] <= wr_data;
    end
  end

  always_comb begin
    full_d    = full_q;
    wr_page_d = wr_page_q;
    rd_page_d = rd_page_q;
    if (wr_frame_done && wr_ready) begin
      full_d[wr_page_q] = 1'b1;
      wr_page_d         = !wr_page_q;
    end
    if (rd_frame_done && rd_frame_valid) begin
      full_d[rd_page_q] = 1'b0;
      rd_page_d         = !rd_page_q;
    end
    drop_d = drop_q || ((wr_en || wr_frame_done) && !wr_ready);
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_go;
    lane_oor   = '0;
    for (int i = 0; i < LANES; i++) begin
      logic [ADDR_W-1:0] a;
      a           = rd_addr_in_5P[ADDR_W*i +: ADDR_W];
      lane_oor[i] = (a >= DEPTH_A);
      if (rd_en) begin
        if (rd_frame_valid && !lane_oor[i]) begin
          rd_data_d[DATA_W*i +: DATA_W] = mem_q[rd_page_q][a[10:0]];
        end else begin
          rd_data_d[DATA_W*i +: DATA_W] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q     <= '0;
      wr_page_q  <= 1'b0;
      rd_page_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_page_q  <= wr_page_d;
      rd_page_q  <= rd_page_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      drop_q     <= drop_d;
    end
  end

`ifdef C3_FMAP_OOR_ERR_EN
  logic oor_q, oor_d;

  assign oor_d = oor_q || (rd_go && (|lane_oor));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oor_q <= 1'b0;
    end else begin
      oor_q <= oor_d;
    end
  end

  assign oor_err = oor_q;
`else
  logic unused_oor;
  assign unused_oor = ^lane_oor;
  assign oor_err    = 1'b0;
`endif

  assign rd_data_out_5P = rd_data_q;
  assign rd_data_valid  = rd_valid_q;
  assign wr_drop_err    = drop_q;

endmodule
